keypad_scanner: RTL and testbench

- Scans a 4x4 active-low matrix keypad by driving one row low at a time and sampling the column lines.
- Decodes at most one pressed key into a 4-bit hex code and debounces it over whole scan frames.
- Emits one event per press and keeps an 8-digit history, newest digit in the low nibble, formatted to feed the 8-digit display driver (nibble n goes to digit n).
- Input-side counterpart of the multiplexed display: the display scans outputs, this block scans inputs.

---
 rtl/keypad_scanner.sv | 256 +++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner.
// Drives one row low at a time, samples the synchronized columns at the end of
// each row slot, decodes a whole frame into a single key, debounces press and
// release over whole frames, and keeps an 8-digit history of accepted keys.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV     = 10000,
    parameter int unsigned DEBOUNCE_CNT = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  col_n,
    input  logic        clear,
    output logic [3:0]  row_n,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_down,
    output logic [31:0] digits
);

    localparam int unsigned DivW = $clog2(SCAN_DIV);
    localparam int unsigned CntW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DivW-1:0] DivLast   = DivW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] CntTarget = CntW'(DEBOUNCE_CNT);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StDebounce,
        StPressed,
        StRelease
    } state_e;

    // Physical key position (row*4 + col) to hex code.
    function automatic logic [3:0] key_map(input logic [3:0] idx);
        logic [3:0] code;
        code = 4'h0;
        case (idx)
            4'd0:  code = 4'h1;
            4'd1:  code = 4'h2;
            4'd2:  code = 4'h3;
            4'd3:  code = 4'hA;
            4'd4:  code = 4'h4;
            4'd5:  code = 4'h5;
            4'd6:  code = 4'h6;
            4'd7:  code = 4'hB;
            4'd8:  code = 4'h7;
            4'd9:  code = 4'h8;
            4'd10: code = 4'h9;
            4'd11: code = 4'hC;
            4'd12: code = 4'hE;
            4'd13: code = 4'h0;
            4'd14: code = 4'hF;
            4'd15: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    // Synchronizer, scan and state registers
    logic [3:0]      col_meta_q, col_sync_q;
    logic [DivW-1:0] div_q;
    logic [1:0]      row_idx_q;
    logic [11:0]     acc_q;        // rows 0..2; row 3 is used straight from the sync stage
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      cand_q, cand_d;
    logic [3:0]      key_code_q;
    logic            key_valid_q;
    logic            key_down_q;
    logic [31:0]     digits_q;

    logic            sample;
    logic            frame_end;
    logic [15:0]     frame_bits;
    logic [1:0]      n_set;        // saturates at 2 (= two or more)
    logic [3:0]      hit_idx;
    logic [3:0]      hit_code;
    logic            frame_key;
    logic [CntW-1:0] cnt_inc;
    logic            accept;
    logic            release_done;

    assign sample    = (div_q == DivLast);
    assign frame_end = sample && (row_idx_q == 2'd3);
    assign row_n     = ~(4'b0001 << row_idx_q);

    // Two-stage synchronizer for the asynchronous column lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_q <= 4'hF;
            col_sync_q <= 4'hF;
        end else begin
            col_meta_q <= col_n;
            col_sync_q <= col_meta_q;
        end
    end

    // Row slot divider and row index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            row_idx_q <= 2'd0;
        end else if (sample) begin
            div_q     <= '0;
            row_idx_q <= row_idx_q + 2'd1;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Capture pressed columns (active-high) for rows 0..2 of the current frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (sample) begin
            case (row_idx_q)
                2'd0:    acc_q[3:0]  <= ~col_sync_q;
                2'd1:    acc_q[7:4]  <= ~col_sync_q;
                2'd2:    acc_q[11:8] <= ~col_sync_q;
                default: acc_q       <= acc_q;
            endcase
        end
    end

    // Frame decode: count set bits (saturating) and remember the last hit position
    always_comb begin
        frame_bits = {~col_sync_q, acc_q};
        n_set      = 2'd0;
        hit_idx    = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame_bits[i]) begin
                if (n_set != 2'd2) n_set = n_set + 2'd1;
                hit_idx = 4'(i);
            end
        end
    end

    // Multiple keys are indistinguishable from ghosting, so only a lone key counts
    assign frame_key = (n_set == 2'd1);
    assign hit_code  = key_map(hit_idx);
    assign cnt_inc   = (cnt_q >= CntTarget) ? cnt_q : cnt_q + 1'b1;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cand_q  <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
        end
    end

    // FSM next state; only advances on frame-end edges
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cand_d       = cand_q;
        accept       = 1'b0;
        release_done = 1'b0;
        if (frame_end) begin
            unique case (state_q)
                StIdle: begin
                    if (frame_key) begin
                        cand_d = hit_code;
                        if (DEBOUNCE_CNT == 1) begin
                            accept  = 1'b1;
                            state_d = StPressed;
                            cnt_d   = '0;
                        end else begin
                            cnt_d   = CntOne;
                            state_d = StDebounce;
                        end
                    end
                end
                StDebounce: begin
                    if (!frame_key) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (hit_code == cand_q) begin
                        if (cnt_inc >= CntTarget) begin
                            accept  = 1'b1;
                            state_d = StPressed;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cand_d = hit_code;
                        cnt_d  = CntOne;
                    end
                end
                StPressed: begin
                    if (!frame_key) begin
                        if (DEBOUNCE_CNT == 1) begin
                            release_done = 1'b1;
                            state_d      = StIdle;
                            cnt_d        = '0;
                        end else begin
                            state_d = StRelease;
                            cnt_d   = CntOne;
                        end
                    end
                end
                StRelease: begin
                    if (frame_key) begin
                        state_d = StPressed;
                        cnt_d   = '0;
                    end else if (cnt_inc >= CntTarget) begin
                        release_done = 1'b1;
                        state_d      = StIdle;
                        cnt_d        = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output registers: event pulse, held key, and digit history with clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
            digits_q    <= '0;
        end else begin
            key_valid_q <= accept;
            if (accept) begin
                key_code_q <= cand_d;
                key_down_q <= 1'b1;
            end else if (release_done) begin
                key_down_q <= 1'b0;
            end
            // A clear landing on an accept edge still keeps the new key
            if (clear) begin
                digits_q <= accept ? {28'h0, cand_d} : 32'h0;
            end else if (accept) begin
                digits_q <= {digits_q[27:0], cand_d};
            end
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;
    assign digits    = digits_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural keypad model.
// Expected key events are queued when a press is driven and checked when
// key_valid pulses.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV     = 4;
    localparam int unsigned DEBOUNCE_CNT = 3;
    localparam int unsigned FRAME        = 4 * SCAN_DIV;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] digits;
        int unsigned cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  col_n;
    logic        clear;
    logic [3:0]  row_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [31:0] digits;

    logic [15:0] kp;            // pressed keys, index row*4+col
    logic [3:0]  kmap [16];
    exp_t        sb_q [$];
    logic [31:0] md;            // model of the digit history
    int unsigned cyc;
    int unsigned c0;
    int          checks;
    int          failures;
    logic        valid_prev;

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_n     (col_n),
        .clear     (clear),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down),
        .digits    (digits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Keypad: a column reads low when a pressed key sits on the driven row
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (kp[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stop at the first negedge of row 0, i.e. the start of a frame
    task automatic align();
        int n;
        n = 0;
        while (row_n !== 4'b0111 && n < 64) begin
            @(negedge clk);
            n++;
        end
        while (row_n !== 4'b1110 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) check("align_timeout", {28'h0, row_n}, 32'he);
        c0 = cyc;
    endtask

    // A press held from frame start is accepted at the end of frame DEBOUNCE_CNT
    task automatic expect_press(input logic [3:0] code, input logic clear_hit);
        exp_t e;
        md       = clear_hit ? {28'h0, code} : {md[27:0], code};
        e.code   = code;
        e.digits = md;
        e.cyc    = c0 + DEBOUNCE_CNT * FRAME;
        sb_q.push_back(e);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
    endtask

    // Event monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_prev) check("pulse_width", {31'h0, key_valid}, 32'h0);
            if (key_valid) begin
                if (sb_q.size() == 0) begin
                    check("spurious_valid", {31'h0, key_valid}, 32'h0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("pulse_code", {28'h0, key_code}, {28'h0, e.code});
                    check("pulse_digits", digits, e.digits);
                    check("pulse_cycle", cyc, e.cyc);
                end
            end
            valid_prev <= key_valid;
        end else begin
            valid_prev <= 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        kmap = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                 4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
        checks   = 0;
        failures = 0;
        cyc      = 0;
        c0       = 0;
        md       = '0;
        kp       = '0;
        clear    = 1'b0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_row_n", {28'h0, row_n}, 32'he);
        check("rst_key_valid", {31'h0, key_valid}, 32'h0);
        check("rst_key_down", {31'h0, key_down}, 32'h0);
        check("rst_key_code", {28'h0, key_code}, 32'h0);
        check("rst_digits", digits, 32'h0);
        cycles(3);
        rst_n = 1'b1;

        // Press r1c1 for 5 frames, then release
        align();
        expect_press(kmap[5], 1'b0);
        kp = 16'h1 << 5;
        cycles(40);
        check("press_down_early", {31'h0, key_down}, 32'h0);
        cycles(40);
        check("press_down", {31'h0, key_down}, 32'h1);
        check("press_code", {28'h0, key_code}, 32'h5);
        check("press_digits", digits, 32'h5);
        kp = '0;
        cycles(2 * FRAME);
        check("release_held", {31'h0, key_down}, 32'h1);
        cycles(FRAME);
        check("release_done", {31'h0, key_down}, 32'h0);

        // Bounce: r2c2 for only 2 frames
        align();
        kp = 16'h1 << 10;
        cycles(2 * FRAME);
        kp = '0;
        cycles(4 * FRAME);
        check("bounce_digits", digits, md);
        check("bounce_down", {31'h0, key_down}, 32'h0);

        // Ghost: r0c0 and r0c1 together
        align();
        kp = 16'h0003;
        cycles(6 * FRAME);
        check("ghost_down", {31'h0, key_down}, 32'h0);
        kp = '0;
        cycles(FRAME);
        check("ghost_digits", digits, md);

        pulse_clear();
        md = '0;
        check("clear1_digits", digits, 32'h0);
        check("clear1_code", {28'h0, key_code}, 32'h5);

        // History: r0c0, r0c1, r0c2
        for (int i = 0; i < 3; i++) begin
            align();
            expect_press(kmap[i], 1'b0);
            kp = 16'h1 << i;
            cycles(4 * FRAME);
            check("hist_down", {31'h0, key_down}, 32'h1);
            kp = '0;
            cycles(4 * FRAME);
            check("hist_up", {31'h0, key_down}, 32'h0);
        end
        check("hist_digits", digits, 32'h00000123);
        pulse_clear();
        md = '0;
        check("clear2_digits", digits, 32'h0);
        check("clear2_code", {28'h0, key_code}, 32'h3);

        // Release glitch on r3c1
        align();
        expect_press(kmap[13], 1'b0);
        kp = 16'h1 << 13;
        cycles(4 * FRAME);
        kp = '0;
        cycles(FRAME);
        kp = 16'h1 << 13;
        cycles(FRAME);
        check("glitch_down", {31'h0, key_down}, 32'h1);
        cycles(FRAME);
        kp = '0;
        cycles(4 * FRAME);
        check("glitch_up", {31'h0, key_down}, 32'h0);

        // Clear on the accept edge of r3c3
        align();
        expect_press(kmap[15], 1'b1);
        kp = 16'h1 << 15;
        cycles(DEBOUNCE_CNT * FRAME - 1);
        pulse_clear();
        cycles(FRAME);
        kp = '0;
        cycles(4 * FRAME);
        check("collide_digits", digits, 32'h0000000D);
        check("collide_code", {28'h0, key_code}, 32'hD);

        // Asynchronous reset mid-scan with a key held and accepted
        align();
        expect_press(kmap[5], 1'b0);
        kp = 16'h1 << 5;
        cycles(56);
        check("prereset_down", {31'h0, key_down}, 32'h1);
        #3 rst_n = 1'b0;
        #1;
        check("async_row_n", {28'h0, row_n}, 32'he);
        check("async_key_valid", {31'h0, key_valid}, 32'h0);
        check("async_key_down", {31'h0, key_down}, 32'h0);
        check("async_key_code", {28'h0, key_code}, 32'h0);
        check("async_digits", digits, 32'h0);
        kp = '0;
        md = '0;
        cycles(3);
        rst_n = 1'b1;
        cycles(2 * FRAME);
        check("post_reset_digits", digits, 32'h0);

        check("sb_pending", sb_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
